// File: rtl/ex_mem_stage_if.sv
// ID/EX operands and control into the execute stage, EX/MEM pipeline register outputs back out.
interface ex_mem_stage_if;
  logic        Stall;
  logic        Flush;
  logic [63:0] PC_addr;
  logic [63:0] read_data1;
  logic [63:0] read_data2;
  logic [63:0] imm_val;
  logic [3:0]  funct_in;
  logic [4:0]  rd_in;
  logic        MemtoReg;
  logic        RegWrite;
  logic        Branch;
  logic        MemWrite;
  logic        MemRead;
  logic        ALUSrc;
  logic [1:0]  ALU_op;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic [63:0] wb_data;

  logic [63:0] alu_result_store;
  logic [63:0] write_data_store;
  logic [63:0] branch_target_store;
  logic [4:0]  rd_store;
  logic        zero_store;
  logic        branch_taken_store;
  logic        MemtoReg_store;
  logic        RegWrite_store;
  logic        MemWrite_store;
  logic        MemRead_store;

  modport slave (
    input  Stall, Flush, PC_addr, read_data1, read_data2, imm_val, funct_in, rd_in,
           MemtoReg, RegWrite, Branch, MemWrite, MemRead, ALUSrc, ALU_op,
           ForwardA, ForwardB, wb_data,
    output alu_result_store, write_data_store, branch_target_store, rd_store,
           zero_store, branch_taken_store, MemtoReg_store, RegWrite_store,
           MemWrite_store, MemRead_store
  );

  modport master (
    output Stall, Flush, PC_addr, read_data1, read_data2, imm_val, funct_in, rd_in,
           MemtoReg, RegWrite, Branch, MemWrite, MemRead, ALUSrc, ALU_op,
           ForwardA, ForwardB, wb_data,
    input  alu_result_store, write_data_store, branch_target_store, rd_store,
           zero_store, branch_taken_store, MemtoReg_store, RegWrite_store,
           MemWrite_store, MemRead_store
  );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage with forwarding, ALU and branch resolve, registered into EX/MEM.
// One-edge latency; Stall holds the register, Flush clears it, reset overrides both.
module ex_mem_stage (
  input logic           clk,
  input logic           reset,
  ex_mem_stage_if.slave bus
);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL
  } alu_fn_t;

  alu_fn_t     alu_fn;
  logic [63:0] op_a;
  logic [63:0] fwd_b;
  logic [63:0] op_b;
  logic [63:0] result;
  logic [63:0] target;
  logic        cond;

  always_comb begin
    // Code 10 reads the register's current value, i.e. the previous instruction's result.
    case (bus.ForwardA)
      2'b10:   op_a = bus.alu_result_store;
      2'b01:   op_a = bus.wb_data;
      default: op_a = bus.read_data1;
    endcase
    case (bus.ForwardB)
      2'b10:   fwd_b = bus.alu_result_store;
      2'b01:   fwd_b = bus.wb_data;
      default: fwd_b = bus.read_data2;
    endcase
    op_b = bus.ALUSrc ? bus.imm_val : fwd_b;
  end

  always_comb begin
    alu_fn = ALU_ADD;
    case (bus.ALU_op)
      2'b00: alu_fn = ALU_ADD;
      2'b01: alu_fn = ALU_SUB;
      2'b10: begin
        case (bus.funct_in)
          4'b1000: alu_fn = ALU_SUB;
          4'b0111: alu_fn = ALU_AND;
          4'b0110: alu_fn = ALU_OR;
          4'b0100: alu_fn = ALU_XOR;
          4'b0001: alu_fn = ALU_SLL;
          4'b0101: alu_fn = ALU_SRL;
          default: alu_fn = ALU_ADD;
        endcase
      end
      default: begin
        case (bus.funct_in[2:0])
          3'b111:  alu_fn = ALU_AND;
          3'b110:  alu_fn = ALU_OR;
          3'b100:  alu_fn = ALU_XOR;
          3'b001:  alu_fn = ALU_SLL;
          3'b101:  alu_fn = ALU_SRL;
          default: alu_fn = ALU_ADD;
        endcase
      end
    endcase
  end

  always_comb begin
    case (alu_fn)
      ALU_SUB: result = op_a - op_b;
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_XOR: result = op_a ^ op_b;
      ALU_SLL: result = op_a << op_b[5:0];
      ALU_SRL: result = op_a >> op_b[5:0];
      default: result = op_a + op_b;
    endcase
  end

  // Branches compare against the forwarded rs2, never the immediate.
  always_comb begin
    case (bus.funct_in[2:0])
      3'b000:  cond = (op_a == fwd_b);
      3'b001:  cond = (op_a != fwd_b);
      3'b100:  cond = ($signed(op_a) < $signed(fwd_b));
      3'b101:  cond = ($signed(op_a) >= $signed(fwd_b));
      default: cond = 1'b0;
    endcase
    target = bus.PC_addr + {bus.imm_val[62:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset || bus.Flush) begin
      bus.alu_result_store    <= '0;
      bus.write_data_store    <= '0;
      bus.branch_target_store <= '0;
      bus.rd_store            <= '0;
      bus.zero_store          <= 1'b0;
      bus.branch_taken_store  <= 1'b0;
      bus.MemtoReg_store      <= 1'b0;
      bus.RegWrite_store      <= 1'b0;
      bus.MemWrite_store      <= 1'b0;
      bus.MemRead_store       <= 1'b0;
    end else if (!bus.Stall) begin
      bus.alu_result_store    <= result;
      bus.write_data_store    <= fwd_b;
      bus.branch_target_store <= target;
      bus.rd_store            <= bus.rd_in;
      bus.zero_store          <= (result == 64'd0);
      bus.branch_taken_store  <= bus.Branch & cond;
      bus.MemtoReg_store      <= bus.MemtoReg;
      bus.RegWrite_store      <= bus.RegWrite & (bus.rd_in != 5'd0);
      bus.MemWrite_store      <= bus.MemWrite;
      bus.MemRead_store       <= bus.MemRead;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed checks of the EX/MEM stage; expected register contents are queued at drive time.
module tb_ex_mem_stage;

  logic clk;
  logic reset;

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] alu;
    logic [63:0] wd;
    logic [63:0] bt;
    logic [4:0]  rd;
    logic        z;
    logic        tk;
    logic        m2r;
    logic        rw;
    logic        mw;
    logic        mr;
  } out_t;

  out_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic out_t mk(input logic [63:0] alu, input logic [63:0] wd,
                              input logic [63:0] bt, input logic [4:0] rd,
                              input logic z, input logic tk, input logic m2r,
                              input logic rw, input logic mw, input logic mr);
    out_t o;
    o = '{alu: alu, wd: wd, bt: bt, rd: rd, z: z, tk: tk, m2r: m2r, rw: rw, mw: mw, mr: mr};
    return o;
  endfunction

  task automatic clear_in();
    bus.Stall      = 1'b0;
    bus.Flush      = 1'b0;
    bus.PC_addr    = '0;
    bus.read_data1 = '0;
    bus.read_data2 = '0;
    bus.imm_val    = '0;
    bus.funct_in   = '0;
    bus.rd_in      = '0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.Branch     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.MemRead    = 1'b0;
    bus.ALUSrc     = 1'b0;
    bus.ALU_op     = '0;
    bus.ForwardA   = '0;
    bus.ForwardB   = '0;
    bus.wb_data    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag);
    out_t act;
    out_t want;
    act = '{alu: bus.alu_result_store, wd: bus.write_data_store,
            bt: bus.branch_target_store, rd: bus.rd_store, z: bus.zero_store,
            tk: bus.branch_taken_store, m2r: bus.MemtoReg_store,
            rw: bus.RegWrite_store, mw: bus.MemWrite_store, mr: bus.MemRead_store};
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL %s: scoreboard empty, observed alu=%h", tag, act.alu);
    end else begin
      want = sb.pop_front();
      assert (act === want) else begin
        n_bad++;
        $error("FAIL %s: observed alu=%h wd=%h bt=%h rd=%0d z%b tk%b ctl=%b%b%b%b expected alu=%h wd=%h bt=%h rd=%0d z%b tk%b ctl=%b%b%b%b",
               tag, act.alu, act.wd, act.bt, act.rd, act.z, act.tk, act.m2r, act.rw, act.mw, act.mr,
               want.alu, want.wd, want.bt, want.rd, want.z, want.tk, want.m2r, want.rw, want.mw, want.mr);
      end
    end
  endtask

  initial begin
    out_t zero_o;
    out_t held;
    zero_o = mk(64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    clear_in();
    reset = 1'b1;
    sb.push_back(zero_o);
    tick(); check("reset");
    reset = 1'b0;

    // R-type sub
    clear_in();
    bus.read_data1 = 64'd7; bus.read_data2 = 64'd5; bus.ALU_op = 2'b10;
    bus.funct_in = 4'b1000; bus.rd_in = 5'd3; bus.RegWrite = 1'b1;
    sb.push_back(mk(64'd2, 64'd5, 64'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(); check("rtype_sub");

    // beq taken
    clear_in();
    bus.read_data1 = 64'd9; bus.read_data2 = 64'd9; bus.Branch = 1'b1;
    bus.ALU_op = 2'b01; bus.PC_addr = 64'h100; bus.imm_val = 64'd8;
    sb.push_back(mk(64'd0, 64'd9, 64'h110, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); check("beq");

    // forwarding pair
    clear_in();
    bus.read_data1 = 64'h18; bus.read_data2 = 64'd8; bus.ALU_op = 2'b10;
    bus.rd_in = 5'd5; bus.RegWrite = 1'b1;
    sb.push_back(mk(64'h20, 64'd8, 64'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(); check("fwd_setup");

    clear_in();
    bus.read_data1 = 64'hdead; bus.read_data2 = 64'hdead; bus.ALU_op = 2'b10;
    bus.ForwardA = 2'b10; bus.ForwardB = 2'b01; bus.wb_data = 64'd3;
    bus.rd_in = 5'd6; bus.RegWrite = 1'b1;
    sb.push_back(mk(64'h23, 64'd3, 64'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(); check("fwd_a10_b01");

    // store with forwarded data
    clear_in();
    bus.ALUSrc = 1'b1; bus.imm_val = 64'd16; bus.read_data1 = 64'h1000;
    bus.read_data2 = 64'h99; bus.ForwardB = 2'b01; bus.wb_data = 64'hAB; bus.MemWrite = 1'b1;
    sb.push_back(mk(64'h1010, 64'hAB, 64'h20, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick(); check("store");

    // andi with rd=0 suppresses RegWrite
    clear_in();
    bus.ALU_op = 2'b11; bus.funct_in = 4'b0111; bus.ALUSrc = 1'b1;
    bus.read_data1 = 64'hF0F0; bus.imm_val = 64'hFF; bus.read_data2 = 64'h55;
    bus.RegWrite = 1'b1; bus.MemtoReg = 1'b1; bus.MemRead = 1'b1;
    held = mk(64'hF0, 64'h55, 64'h1FE, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    sb.push_back(held);
    tick(); check("rd0_andi");

    // stall for three edges, then resume with the same inputs
    clear_in();
    bus.read_data1 = 64'd1; bus.read_data2 = 64'd1; bus.ALU_op = 2'b10;
    bus.funct_in = 4'b0001; bus.rd_in = 5'd9; bus.RegWrite = 1'b1; bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(held);
      tick(); check("stall_hold");
    end
    bus.Stall = 1'b0;
    sb.push_back(mk(64'd2, 64'd1, 64'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(); check("stall_release_sll");

    bus.Stall = 1'b1; bus.Flush = 1'b1;
    sb.push_back(zero_o);
    tick(); check("flush_stall");

    // shift amount uses only opB[5:0]
    clear_in();
    bus.ALU_op = 2'b11; bus.funct_in = 4'b0001; bus.ALUSrc = 1'b1;
    bus.imm_val = 64'd65; bus.read_data1 = 64'd3; bus.rd_in = 5'd4; bus.RegWrite = 1'b1;
    sb.push_back(mk(64'd6, 64'd0, 64'h82, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(); check("slli_65");

    clear_in();
    bus.ALU_op = 2'b10; bus.funct_in = 4'b0101; bus.read_data1 = 64'h80;
    bus.read_data2 = 64'd3; bus.rd_in = 5'd4; bus.RegWrite = 1'b1;
    sb.push_back(mk(64'h10, 64'd3, 64'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(); check("srl");

    // signed branches: -1 vs 1, negative offset
    clear_in();
    bus.ALU_op = 2'b01; bus.funct_in = 4'b0100; bus.Branch = 1'b1;
    bus.read_data1 = '1; bus.read_data2 = 64'd1;
    bus.PC_addr = 64'h200; bus.imm_val = 64'hFFFF_FFFF_FFFF_FFFE;
    sb.push_back(mk(64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'h1FC, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); check("blt_taken");

    bus.funct_in = 4'b0101; bus.PC_addr = '0; bus.imm_val = '0;
    sb.push_back(mk(64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); check("bge_not_taken");

    // forward code 11 behaves as register data
    clear_in();
    bus.ALU_op = 2'b10; bus.funct_in = 4'b0100; bus.ForwardA = 2'b11; bus.ForwardB = 2'b11;
    bus.wb_data = 64'h77; bus.read_data1 = 64'd10; bus.read_data2 = 64'd10;
    sb.push_back(mk(64'd0, 64'd10, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); check("fwd11_xor_zero");

    clear_in();
    bus.ALU_op = 2'b10; bus.funct_in = 4'b0110; bus.read_data1 = 64'h0F;
    bus.read_data2 = 64'hF0; bus.rd_in = 5'd7; bus.RegWrite = 1'b1; bus.MemWrite = 1'b1;
    sb.push_back(mk(64'hFF, 64'hF0, 64'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    tick(); check("or");

    clear_in();
    bus.ForwardB = 2'b10; bus.read_data1 = 64'd1; bus.read_data2 = 64'h5;
    bus.rd_in = 5'd8; bus.RegWrite = 1'b1;
    sb.push_back(mk(64'h100, 64'hFF, 64'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(); check("fwd_b10_store_data");

    // reset mid-stall with live inputs, then capture resumes
    bus.Stall = 1'b1; bus.MemWrite = 1'b1; bus.MemtoReg = 1'b1;
    reset = 1'b1;
    sb.push_back(zero_o);
    tick(); check("reset_mid_stall");
    reset = 1'b0;

    clear_in();
    bus.read_data1 = 64'd5; bus.read_data2 = 64'd6; bus.rd_in = 5'd2; bus.RegWrite = 1'b1;
    sb.push_back(mk(64'd11, 64'd6, 64'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(); check("post_reset_add");

    bus.ALU_op = 2'b10; bus.funct_in = 4'b0010; bus.read_data1 = 64'd2; bus.read_data2 = 64'd3;
    sb.push_back(mk(64'd5, 64'd3, 64'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(); check("unknown_funct_add");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
